// File: rtl/mem_model_pkg.sv
// Shared types and helpers for the dual-port packet/address memory model.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_model_pkg;

   typedef enum logic {INIT, RUN} mem_state_e;

   // Same-address collision policy selectors
   localparam int RD_FIRST = 0;
   localparam int WR_FIRST = 1;

   // Byte-lane merge: take the new byte when its enable is set
   function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                           input logic [7:0] new_b,
                                           input logic       be);
      return be ? new_b : old_b;
   endfunction

   // Even parity bit for one byte lane
   function automatic logic byte_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read response pipeline: LAT registered valid/data stages.
// Latency: LAT cycles from req_vld to rsp_vld.
// Backpressure: none; one entry per cycle, data stages hold when not loaded.
module mem_rd_pipe #(
   parameter int W   = 32,
   parameter int LAT = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         req_vld,
   input  logic [W-1:0] req_dat,
   output logic         rsp_vld,
   output logic [W-1:0] rsp_dat
);

   logic [LAT-1:0] vld_q;
   logic [W-1:0]   dat_q [LAT];

   // Shift valids every cycle; data stages only load behind a valid so the output holds
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
      end else begin
         vld_q[0] <= req_vld;
         if (req_vld) dat_q[0] <= req_dat;
         for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign rsp_vld = vld_q[LAT-1];
   assign rsp_dat = dat_q[LAT-1];

endmodule

// File: rtl/mem_model_dp.sv
// Dual-port synchronous memory with byte enables, collision policy and post-reset clear.
// Latency: READ_LAT (1 or 2) cycles from accepted read to rd_rvalid; writes land at the accepting edge.
// Backpressure: ready low only while clearing; no response backpressure. Option MEM_MODEL_DP_PARITY_EN adds per-byte parity and par_err.
module mem_model_dp
   import mem_model_pkg::*;
#(
   parameter int              DWIDTH    = 32,
   parameter int              AWIDTH    = 10,
   parameter int              MEM_DEPTH = 1 << AWIDTH,
   parameter int              READ_LAT  = 1,
   parameter int              RD_MODE   = RD_FIRST,
   parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
   input  logic                clk,
   input  logic                reset_n,
   output logic                init_done,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [AWIDTH-1:0]   wr_addr,
   input  logic [DWIDTH-1:0]   wr_data,
   input  logic [DWIDTH/8-1:0] wr_be,
   input  logic                rd_valid,
   output logic                rd_ready,
   input  logic [AWIDTH-1:0]   rd_addr,
   output logic                rd_rvalid,
   output logic [DWIDTH-1:0]   rd_rdata,
   output logic                addr_err
`ifdef MEM_MODEL_DP_PARITY_EN
  ,output logic                par_err
`endif
);

   localparam int                NB    = DWIDTH / 8;
   localparam logic [AWIDTH:0]   DEPTH = (AWIDTH+1)'(MEM_DEPTH);
   localparam logic [AWIDTH-1:0] LAST  = AWIDTH'(MEM_DEPTH - 1);
`ifdef MEM_MODEL_DP_PARITY_EN
   localparam int PW = DWIDTH + 1;
`else
   localparam int PW = DWIDTH;
`endif

   mem_state_e          state;
   logic [AWIDTH-1:0]   ptr;
   logic                run_q;
   logic [DWIDTH-1:0]   mem [MEM_DEPTH];

   logic                wr_acc, rd_acc, wr_in, rd_in, rd_fwd;
   logic [DWIDTH-1:0]   wr_old, wr_merged, rd_word;
   logic [PW-1:0]       pipe_in, pipe_out;

   assign init_done = run_q;
   assign wr_ready  = run_q;
   assign rd_ready  = run_q;

   assign wr_acc = wr_valid & run_q;
   assign rd_acc = rd_valid & run_q;
   assign wr_in  = {1'b0, wr_addr} < DEPTH;
   assign rd_in  = {1'b0, rd_addr} < DEPTH;
   assign rd_fwd = (RD_MODE == WR_FIRST) && wr_acc && wr_in && (wr_addr == rd_addr);
   assign wr_old = wr_in ? mem[wr_addr] : '0;

   // Merge enabled write lanes over the current word
   always_comb begin
      wr_merged = wr_old;
      for (int i = 0; i < NB; i++)
         wr_merged[8*i +: 8] = be_merge(wr_old[8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
   end

   // Read word selection: out-of-range reads return zero, write-first forwards the merged word
   always_comb begin
      rd_word = '0;
      if (rd_in) rd_word = rd_fwd ? wr_merged : mem[rd_addr];
   end

   // Clear sequencer walks ptr once after reset, then the block stays in RUN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= INIT;
         ptr   <= '0;
         run_q <= 1'b0;
      end else begin
         unique case (state)
            INIT: begin
               if (ptr == LAST) begin
                  state <= RUN;
                  run_q <= 1'b1;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Single array write port shared by the clear sequencer and accepted writes
   always_ff @(posedge clk) begin
      if (state == INIT)
         mem[ptr] <= INIT_VAL;
      else if (wr_acc && wr_in && (|wr_be))
         mem[wr_addr] <= wr_merged;
   end

   // Flag any accepted request whose address lies beyond the populated depth
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) addr_err <= 1'b0;
      else          addr_err <= (wr_acc & ~wr_in) | (rd_acc & ~rd_in);
   end

`ifdef MEM_MODEL_DP_PARITY_EN
   logic [NB-1:0] par_mem [MEM_DEPTH];
   logic [NB-1:0] wr_par, init_par;
   logic          rd_perr;

   // Parity of the merged write word, of the clear value, and check of the stored word
   always_comb begin
      wr_par   = '0;
      init_par = '0;
      rd_perr  = 1'b0;
      for (int i = 0; i < NB; i++) begin
         wr_par[i]   = byte_parity(wr_merged[8*i +: 8]);
         init_par[i] = byte_parity(INIT_VAL[8*i +: 8]);
      end
      if (rd_in && !rd_fwd)
         for (int i = 0; i < NB; i++)
            rd_perr = rd_perr | (byte_parity(mem[rd_addr][8*i +: 8]) ^ par_mem[rd_addr][i]);
   end

   // Parity array follows the data array write port
   always_ff @(posedge clk) begin
      if (state == INIT)
         par_mem[ptr] <= init_par;
      else if (wr_acc && wr_in && (|wr_be))
         par_mem[wr_addr] <= wr_par;
   end

   assign pipe_in = {rd_perr, rd_word};
   assign rd_rdata = pipe_out[DWIDTH-1:0];
   assign par_err  = pipe_out[DWIDTH] & rd_rvalid;
`else
   assign pipe_in  = rd_word;
   assign rd_rdata = pipe_out;
`endif

   mem_rd_pipe #(.W(PW), .LAT(READ_LAT)) u_rd_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .req_vld (rd_acc),
      .req_dat (pipe_in),
      .rsp_vld (rd_rvalid),
      .rsp_dat (pipe_out)
   );

endmodule

// File: doc/mem_model_dp.md
Name: mem_model_dp

Overview:
- Parametrised dual-port synchronous memory for the Ethernet MAC.
- Successor to the single-port combinational-read switch-address/packet-data memory model.
- Adds registered read with configurable latency, byte write enables, valid/ready request handshakes, a defined read/write collision mode, and a post-reset clear sequencer.
- Used for packet-data FIFOs and the switch address table in the tx/rx controllers.

Parameters:
- DWIDTH, 32, data word width in bits; must be a multiple of 8.
- AWIDTH, 10, address width in bits.
- MEM_DEPTH, 1<<AWIDTH, number of words; must be ≤ 1<<AWIDTH.
- READ_LAT, 1, read latency from accepted request to rd_rvalid; legal values 1 or 2.
- RD_MODE, 0, same-address collision policy: 0 = read-first (old data), 1 = write-first (new merged data).
- INIT_VAL, 0, DWIDTH-bit value written to every word by the clear sequencer.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- init_done  out  1  high once clear sequence has completed
- wr_valid  in  1  write request valid
- wr_ready  out  1  write request ready
- wr_addr  in  AWIDTH  write word address
- wr_data  in  DWIDTH  write data
- wr_be  in  DWIDTH/8  byte enables; bit i covers wr_data[8i+7:8i]
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request ready
- rd_addr  in  AWIDTH  read word address
- rd_rvalid  out  1  read response valid, one-cycle pulse per accepted read
- rd_rdata  out  DWIDTH  read response data
- addr_err  out  1  one-cycle pulse when an accepted request has address ≥ MEM_DEPTH

Behaviour:
- Clocking and reset:
  - Single clock clk.
  - reset_n is asynchronous, active-low.
  - All control registers reset asynchronously. The array itself is not reset.
- Reset values: init_done=0, wr_ready=0, rd_ready=0, rd_rvalid=0, rd_rdata=0, addr_err=0, FSM=INIT, clear pointer=0.
- FSM:
  - INIT: each cycle writes INIT_VAL to mem[ptr] and increments ptr. At ptr==MEM_DEPTH-1 the last word is written and the FSM moves to RUN.
  - Clearing takes exactly MEM_DEPTH cycles after reset deassertion.
  - RUN: init_done=1, wr_ready=1, rd_ready=1. RUN is terminal until reset.
- Reset during INIT or RUN restarts the clear sequence from ptr=0. Any in-flight reads are dropped: rd_rvalid=0, no response is issued.
- Handshake: a request is accepted when valid&&ready. No request is accepted during INIT. Requesters hold valid and payload until accepted.
- Write:
  - On acceptance, mem[wr_addr] is updated at the clock edge, byte lanes per wr_be.
  - wr_be=0 is accepted with no array change.
- Read:
  - READ_LAT=1: rd_rdata/rd_rvalid are registered at the edge after acceptance.
  - READ_LAT=2: one extra output register stage; fully pipelined, one read accepted per cycle.
  - rd_rdata holds its last value when rd_rvalid=0.
- Collision (same-cycle accepted read and write, same address):
  - RD_MODE=0: returns pre-write contents.
  - RD_MODE=1: returns old word with the wr_be lanes replaced by wr_data.
  - Different addresses: independent.
- Out-of-range address (≥ MEM_DEPTH):
  - Write: ignored.
  - Read: returns 0 with rd_rvalid=1.
  - Both cases: addr_err pulses the cycle after acceptance.
- Back-to-back reads and writes at full rate are supported. There is no response backpressure.

Optional Feature:
- Macro: MEM_MODEL_DP_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit per byte lane, computed on write after the byte merge. The clear sequencer writes parity consistent with INIT_VAL.
  - Reads recompute parity. Adds output port par_err (1 bit) that pulses aligned with rd_rvalid on mismatch.
  - Out-of-range reads never flag par_err.
- Undefined: no parity storage and no par_err port; behaviour otherwise identical.

Decomposition:
- Package mem_model_pkg:
  - typedef enum {INIT, RUN} mem_state_e
  - constants RD_FIRST=0, WR_FIRST=1
  - function be_merge(old, new, be)
  - function byte_parity(data)
- Sub-module mem_rd_pipe: READ_LAT-deep valid/data pipeline with reset clearing valid stages.

Test Plan:
- Reset → clear time, AWIDTH=4, INIT_VAL=32'hA5A5A5A5: release reset → init_done rises exactly 16 cycles later; read addresses 0..15 → all return A5A5A5A5.
- Byte-enable merge: write addr 3 = 32'h11223344 with be=4'hF, then write addr 3 = 32'hAABBCCDD with be=4'b0101 → read addr 3 returns 32'h11BB33DD after READ_LAT cycles.
- Collision: addr 5 holds 0; same-cycle write 32'hDEADBEEF (be=F) and read addr 5 → RD_MODE=0 returns 0, RD_MODE=1 returns DEADBEEF; a following read returns DEADBEEF in both modes.
- Pipelined reads, READ_LAT=2: 8 back-to-back reads of addrs 0..7 → 8 consecutive rd_rvalid pulses starting 2 cycles after first accept, data in order.
- Reset mid-operation: assert reset_n=0 with 2 reads in flight → rd_rvalid stays 0 for both reads; init_done=0; clear sequence restarts, and previously written data reads back as INIT_VAL.
- Out-of-range and parity, MEM_DEPTH=12, AWIDTH=4: read addr 14 → rd_rdata=0, addr_err pulse; with MEM_MODEL_DP_PARITY_EN, force one stored parity bit on addr 2 → par_err pulse with rd_rvalid.
